// File: rtl/fetch_pcgen.sv
// Fetch stage / program-counter generator.
// Holds the issue PC, drives a synchronous-read instruction memory and hands
// a valid-tagged instruction with its PC and PC+INC to decode. Redirects from
// execute squash the in-flight slot. Misaligned register/jump targets are
// diverted to the trap vector and reported for one cycle.
module fetch_pcgen #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned       INC        = 4,
  parameter int unsigned       ALIGN_BITS = 2,
  parameter logic [ADDR_W-1:0] TRAP_VEC   = 32'h0000_0080,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic [1:0]         SEL_DIR,
  input  logic [ADDR_W-1:0]  DOA_exe,
  input  logic [ADDR_W-1:0]  jump_exe,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_id,
  output logic [ADDR_W-1:0]  PC_id,
  output logic [ADDR_W-1:0]  PC_4,
  output logic               valid_id,
  output logic               misalign,
  output logic [ADDR_W-1:0]  bad_addr,
  output logic [CNT_W-1:0]   fetch_cnt
);

  localparam logic [ADDR_W-1:0] INC_C        = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK_C = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO_C  = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX_C    = {CNT_W{1'b1}};

  // True when any of the low ALIGN_BITS bits of the address are set.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return (addr & ALIGN_MASK_C) != ADDR_ZERO_C;
  endfunction

  // Architectural state
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] f_pc_r;
  logic [ADDR_W-1:0] pc4_r;
  logic              f_valid_r;
  logic              misalign_r;
  logic [ADDR_W-1:0] bad_addr_r;
  logic [CNT_W-1:0]  cnt_r;

  // Next-state values
  logic [ADDR_W-1:0] pc_s;
  logic [ADDR_W-1:0] f_pc_s;
  logic [ADDR_W-1:0] pc4_s;
  logic              f_valid_s;
  logic              misalign_s;
  logic [ADDR_W-1:0] bad_addr_s;
  logic [CNT_W-1:0]  cnt_s;
  logic [ADDR_W-1:0] target_s;
  logic              redirect_s;

  // Select the redirect target from the execute-stage sources.
  always_comb begin
    target_s   = pc_r;
    redirect_s = 1'b0;
    case (SEL_DIR)
      2'b01: begin
        target_s   = DOA_exe;
        redirect_s = 1'b1;
      end
      2'b10: begin
        target_s   = jump_exe;
        redirect_s = 1'b1;
      end
      2'b11: begin
        target_s   = TRAP_VEC;
        redirect_s = 1'b1;
      end
      default: begin
        target_s   = pc_r;
        redirect_s = 1'b0;
      end
    endcase
  end

  // Next PC, outbound slot and trap reporting: redirect beats stall beats sequential.
  always_comb begin
    pc_s       = pc_r;
    f_pc_s     = f_pc_r;
    pc4_s      = pc4_r;
    f_valid_s  = f_valid_r;
    misalign_s = 1'b0;
    bad_addr_s = bad_addr_r;
    if (redirect_s) begin
      // The address issued this cycle is on the wrong path: squash its slot.
      f_valid_s = 1'b0;
      f_pc_s    = pc_r;
      pc4_s     = pc_r + INC_C;
      if ((SEL_DIR != 2'b11) && is_misaligned(target_s)) begin
        pc_s       = TRAP_VEC;
        misalign_s = 1'b1;
        bad_addr_s = target_s;
      end else begin
        pc_s = target_s;
      end
    end else if (stall) begin
      pc_s      = pc_r;
      f_pc_s    = f_pc_r;
      pc4_s     = pc4_r;
      f_valid_s = f_valid_r;
    end else begin
      f_valid_s = 1'b1;
      f_pc_s    = pc_r;
      pc4_s     = pc_r + INC_C;
      pc_s      = pc_r + INC_C;
    end
  end

  // Saturating count of slots accepted by decode.
  always_comb begin
    cnt_s = cnt_r;
    if (f_valid_r && !stall && (cnt_r != CNT_MAX_C)) begin
      cnt_s = cnt_r + CNT_ONE_C;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State register with synchronous reset overriding every other action.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      f_pc_r     <= RESET_PC;
      pc4_r      <= RESET_PC + INC_C;
      f_valid_r  <= 1'b0;
      misalign_r <= 1'b0;
      bad_addr_r <= ADDR_ZERO_C;
      cnt_r      <= CNT_ZERO_C;
    end else begin
      pc_r       <= pc_s;
      f_pc_r     <= f_pc_s;
      pc4_r      <= pc4_s;
      f_valid_r  <= f_valid_s;
      misalign_r <= misalign_s;
      bad_addr_r <= bad_addr_s;
      cnt_r      <= cnt_s;
    end
  end

  // The memory keeps its last read data while disabled, so a stalled slot stays stable.
  assign imem_addr = pc_r;
  assign imem_en   = !stall && !reset;
  assign instr_id  = imem_data;
  assign PC_id     = f_pc_r;
  assign PC_4      = pc4_r;
  assign valid_id  = f_valid_r;
  assign misalign  = misalign_r;
  assign bad_addr  = bad_addr_r;
  assign fetch_cnt = cnt_r;

endmodule

// File: tb/tb_fetch_pcgen.sv
// Scoreboard bench for fetch_pcgen: the stimulus process pushes hand-computed
// post-edge expectations, a monitor pops one per clock edge and compares.
module tb_fetch_pcgen;

  logic        clock;
  logic        reset;
  logic        stall;
  logic [1:0]  SEL_DIR;
  logic [31:0] DOA_exe;
  logic [31:0] jump_exe;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data;
  logic [31:0] instr_id;
  logic [31:0] PC_id;
  logic [31:0] PC_4;
  logic        valid_id;
  logic        misalign;
  logic [31:0] bad_addr;
  logic [15:0] fetch_cnt;

  // Second instance with a 2-bit counter to observe saturation.
  logic [31:0] imem_addr2;
  logic        imem_en2;
  logic [31:0] instr_id2;
  logic [31:0] PC_id2;
  logic [31:0] PC_4_2;
  logic        valid_id2;
  logic        misalign2;
  logic [31:0] bad_addr2;
  logic [1:0]  fetch_cnt2;

  int n_cmp;
  int n_bad;
  int step_n;

  typedef struct {
    int          step;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        mis;
    logic [31:0] bad;
    logic        en;
  } exp_t;

  exp_t exp_q[$];

  fetch_pcgen u_dut (
    .clock(clock), .reset(reset), .stall(stall), .SEL_DIR(SEL_DIR),
    .DOA_exe(DOA_exe), .jump_exe(jump_exe), .imem_addr(imem_addr),
    .imem_en(imem_en), .imem_data(imem_data), .instr_id(instr_id),
    .PC_id(PC_id), .PC_4(PC_4), .valid_id(valid_id), .misalign(misalign),
    .bad_addr(bad_addr), .fetch_cnt(fetch_cnt)
  );

  fetch_pcgen #(.CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .stall(stall), .SEL_DIR(SEL_DIR),
    .DOA_exe(DOA_exe), .jump_exe(jump_exe), .imem_addr(imem_addr2),
    .imem_en(imem_en2), .imem_data(imem_data), .instr_id(instr_id2),
    .PC_id(PC_id2), .PC_4(PC_4_2), .valid_id(valid_id2), .misalign(misalign2),
    .bad_addr(bad_addr2), .fetch_cnt(fetch_cnt2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory model: word at address A is ~A, held while disabled.
  initial imem_data = 32'h0000_0000;
  always @(posedge clock) begin
    if (imem_en) imem_data <= ~imem_addr;
  end

  task automatic check(input string nm, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imem_addr", e.step, imem_addr, e.addr);
        check("imem_en",   e.step, 32'(imem_en), 32'(e.en));
        check("valid_id",  e.step, 32'(valid_id), 32'(e.vld));
        check("PC_id",     e.step, PC_id, e.pc);
        check("PC_4",      e.step, PC_4, e.pc + 32'd4);
        check("misalign",  e.step, 32'(misalign), 32'(e.mis));
        check("bad_addr",  e.step, bad_addr, e.bad);
        check("fetch_cnt", e.step, 32'(fetch_cnt), 32'(e.cnt));
        check("fetch_cnt_sat", e.step, 32'(fetch_cnt2), 32'(e.cnt2));
        if (e.vld) check("instr_id", e.step, instr_id, ~e.pc);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic cyc(input logic r, input logic s, input logic [1:0] sel,
                     input logic [31:0] tgt, input logic [31:0] a, input logic v,
                     input logic [31:0] pc, input logic [15:0] c, input logic [1:0] c2,
                     input logic m, input logic [31:0] bad, input logic en);
    exp_t e;
    @(negedge clock);
    reset    = r;
    stall    = s;
    SEL_DIR  = sel;
    DOA_exe  = (sel == 2'b01) ? tgt : 32'h0000_0F00;
    jump_exe = (sel == 2'b10) ? tgt : 32'h0000_0E00;
    e.step = step_n;
    e.addr = a;
    e.vld  = v;
    e.pc   = pc;
    e.cnt  = c;
    e.cnt2 = c2;
    e.mis  = m;
    e.bad  = bad;
    e.en   = en;
    exp_q.push_back(e);
    step_n++;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    step_n   = 0;
    reset    = 1'b1;
    stall    = 1'b0;
    SEL_DIR  = 2'b00;
    DOA_exe  = 32'h0000_0000;
    jump_exe = 32'h0000_0000;

    //  rst   stall sel    target        addr          v     PC_id         cnt     c2    mis   bad           en
    cyc(1'b1, 1'b0, 2'b00, 32'h0,        32'h0000_0000, 1'b0, 32'h0000_0000, 16'd0,  2'd0, 1'b0, 32'h0,        1'b0);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0004, 1'b1, 32'h0000_0000, 16'd0,  2'd0, 1'b0, 32'h0,        1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0008, 1'b1, 32'h0000_0004, 16'd1,  2'd1, 1'b0, 32'h0,        1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_000C, 1'b1, 32'h0000_0008, 16'd2,  2'd2, 1'b0, 32'h0,        1'b1);
    // stall three cycles holding PC_id=8
    cyc(1'b0, 1'b1, 2'b00, 32'h0,        32'h0000_000C, 1'b1, 32'h0000_0008, 16'd2,  2'd2, 1'b0, 32'h0,        1'b0);
    cyc(1'b0, 1'b1, 2'b00, 32'h0,        32'h0000_000C, 1'b1, 32'h0000_0008, 16'd2,  2'd2, 1'b0, 32'h0,        1'b0);
    cyc(1'b0, 1'b1, 2'b00, 32'h0,        32'h0000_000C, 1'b1, 32'h0000_0008, 16'd2,  2'd2, 1'b0, 32'h0,        1'b0);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0010, 1'b1, 32'h0000_000C, 16'd3,  2'd3, 1'b0, 32'h0,        1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0014, 1'b1, 32'h0000_0010, 16'd4,  2'd3, 1'b0, 32'h0,        1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0018, 1'b1, 32'h0000_0014, 16'd5,  2'd3, 1'b0, 32'h0,        1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_001C, 1'b1, 32'h0000_0018, 16'd6,  2'd3, 1'b0, 32'h0,        1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0020, 1'b1, 32'h0000_001C, 16'd7,  2'd3, 1'b0, 32'h0,        1'b1);
    // jump to 0x100 from PC 0x20
    cyc(1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0000_0100, 1'b0, 32'h0000_0020, 16'd8, 2'd3, 1'b0, 32'h0,        1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0104, 1'b1, 32'h0000_0100, 16'd8,  2'd3, 1'b0, 32'h0,        1'b1);
    // misaligned register-indirect target
    cyc(1'b0, 1'b0, 2'b01, 32'h0000_0203, 32'h0000_0080, 1'b0, 32'h0000_0104, 16'd9, 2'd3, 1'b1, 32'h0000_0203, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0084, 1'b1, 32'h0000_0080, 16'd9,  2'd3, 1'b0, 32'h0000_0203, 1'b1);
    // trap redirect while stalled: redirect wins
    cyc(1'b0, 1'b1, 2'b11, 32'h0,        32'h0000_0080, 1'b0, 32'h0000_0084, 16'd9,  2'd3, 1'b0, 32'h0000_0203, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0084, 1'b1, 32'h0000_0080, 16'd9,  2'd3, 1'b0, 32'h0000_0203, 1'b1);
    // PC wrap from the top of the address space
    cyc(1'b0, 1'b0, 2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0000_0084, 16'd10, 2'd3, 1'b0, 32'h0000_0203, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 16'd10, 2'd3, 1'b0, 32'h0000_0203, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0004, 1'b1, 32'h0000_0000, 16'd11, 2'd3, 1'b0, 32'h0000_0203, 1'b1);
    // reset mid-run with a jump pending
    cyc(1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'h0000_0000, 16'd0, 2'd0, 1'b0, 32'h0,        1'b0);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0004, 1'b1, 32'h0000_0000, 16'd0,  2'd0, 1'b0, 32'h0,        1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0,        32'h0000_0008, 1'b1, 32'h0000_0004, 16'd1,  2'd1, 1'b0, 32'h0,        1'b1);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() != 0) @(posedge clock);
    end
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
